// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting session controller and its debouncer.
package vote_pkg;

  localparam int N_CAND = 4;
  localparam int IDX_W  = $clog2(N_CAND);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_DEBOUNCE,
    ST_COMMIT,
    ST_RELEASE,
    ST_RESULT
  } state_t;

  // Exactly one button pressed.
  function automatic logic is_onehot(input logic [N_CAND-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [N_CAND-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_debounce.sv
// Capture register plus stability counter: reports when the button pattern has
// held unchanged for DEBOUNCE_CYCLES consecutive samples.
module vote_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              track,
  input  logic [N_CAND-1:0] sample,
  output logic              stable,
  output logic [N_CAND-1:0] pattern
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] cnt;

  // A changed pattern while tracking restarts the stability window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern <= '0;
      cnt     <= '0;
    end else if (load) begin
      pattern <= sample;
      cnt     <= '0;
    end else if (track) begin
      if (sample != pattern) begin
        pattern <= sample;
        cnt     <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign stable = track && (sample == pattern) && (cnt == LAST);

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session FSM: arms one voter at a time, debounces the candidate buttons,
// emits one-hot tally strobes and drives the result-display selector.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             arm,
  input  logic             button1,
  input  logic             button2,
  input  logic             button3,
  input  logic             button4,
  output logic [3:0]       vote_inc,
  output logic             voter_ready,
  output logic             reject,
  output logic [1:0]       disp_sel,
  output logic             disp_valid,
  output logic [CNT_W-1:0] total_votes
);

  state_t            state;
  state_t            next_state;
  logic [N_CAND-1:0] p;
  logic [N_CAND-1:0] captured;
  logic              stable;
  logic              load;
  logic              track;
  logic              decide;
  logic              valid_vote;
  logic              rej_flag;
  logic              prev_zero;

  assign p = {button4, button3, button2, button1};

  assign load       = (state == ST_READY) && !mode && (p != '0);
  assign track      = (state == ST_DEBOUNCE) && !mode && (p != '0);
  assign decide     = stable;
  assign valid_vote = is_onehot(captured);

  vote_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .track  (track),
    .sample (p),
    .stable (stable),
    .pattern(captured)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (mode)     next_state = ST_RESULT;
        else if (arm) next_state = ST_READY;
      end
      ST_READY: begin
        if (mode)           next_state = ST_RESULT;
        else if (p != '0)   next_state = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (mode)           next_state = ST_RESULT;
        else if (p == '0)   next_state = ST_READY;
        else if (decide)    next_state = valid_vote ? ST_COMMIT : ST_RELEASE;
      end
      // A committed vote always completes, whatever mode does.
      ST_COMMIT: next_state = ST_RELEASE;
      ST_RELEASE: begin
        if (mode)           next_state = ST_RESULT;
        else if (p == '0)   next_state = rej_flag ? ST_READY : ST_IDLE;
      end
      ST_RESULT: begin
        if (!mode)          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered at the decision edge so they are high during COMMIT
  // (or the first RELEASE cycle, for a reject).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      vote_inc    <= '0;
      reject      <= 1'b0;
      rej_flag    <= 1'b0;
      total_votes <= '0;
    end else begin
      state    <= next_state;
      vote_inc <= '0;
      reject   <= 1'b0;
      if (decide) begin
        rej_flag <= !valid_vote;
        if (valid_vote) begin
          vote_inc <= captured;
          if (total_votes != '1) total_votes <= total_votes + CNT_W'(1);
        end else begin
          reject <= 1'b1;
        end
      end
    end
  end

  // Display selection only follows a fresh single press from an all-released pad.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_sel  <= '0;
      prev_zero <= 1'b1;
    end else begin
      prev_zero <= (p == '0);
      if (state == ST_RESULT && mode && prev_zero && is_onehot(p)) begin
        disp_sel <= onehot_to_index(p);
      end
    end
  end

  assign voter_ready = (state == ST_READY) || (state == ST_DEBOUNCE);
  assign disp_valid  = (state == ST_RESULT);

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed self-checking bench for vote_session_ctrl (DEBOUNCE_CYCLES=10, CNT_W=8).
module tb_vote_session_ctrl;

  logic       clock;
  logic       reset;
  logic       mode;
  logic       arm;
  logic       button1;
  logic       button2;
  logic       button3;
  logic       button4;
  logic [3:0] vote_inc;
  logic       voter_ready;
  logic       reject;
  logic [1:0] disp_sel;
  logic       disp_valid;
  logic [7:0] total_votes;

  int tests_run;
  int tests_failed;
  int cyc;
  int vote_count;
  int reject_count;
  int conflicts;
  int vote_cyc;
  int press_cyc;
  int base_votes;
  int base_rejects;
  logic [3:0] last_vote;

  vote_session_ctrl #(
    .DEBOUNCE_CYCLES(10),
    .CNT_W(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .arm        (arm),
    .button1    (button1),
    .button2    (button2),
    .button3    (button3),
    .button4    (button4),
    .vote_inc   (vote_inc),
    .voter_ready(voter_ready),
    .reject     (reject),
    .disp_sel   (disp_sel),
    .disp_valid (disp_valid),
    .total_votes(total_votes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor, sampled 1 ns after each rising edge.
  always @(posedge clock) begin
    #1;
    if (vote_inc != 4'b0000) begin
      vote_count = vote_count + 1;
      last_vote  = vote_inc;
      vote_cyc   = cyc;
    end
    if (reject) reject_count = reject_count + 1;
    if (reject && vote_inc != 4'b0000) conflicts = conflicts + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (observed !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b);
    {button4, button3, button2, button1} = b;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic arm_voter();
    @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
  endtask

  task automatic snapshot();
    base_votes   = vote_count;
    base_rejects = reject_count;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0;
    vote_count = 0; reject_count = 0; conflicts = 0; vote_cyc = 0; last_vote = '0;
    reset = 1'b0; mode = 1'b0; arm = 1'b0;
    applyStimulus(4'b0000);

    #50;
    checkOutput("rst_vote_inc", vote_inc, 0);
    checkOutput("rst_ready", voter_ready, 0);
    checkOutput("rst_reject", reject, 0);
    checkOutput("rst_disp_sel", disp_sel, 0);
    checkOutput("rst_disp_valid", disp_valid, 0);
    checkOutput("rst_total", total_votes, 0);
    #50;
    reset = 1'b1;

    // Single valid vote on button1 with latency check.
    arm_voter();
    checkOutput("t1_ready", voter_ready, 1);
    snapshot();
    press_cyc = cyc;
    applyStimulus(4'b0001);
    wait_cycles(20);
    checkOutput("t1_votes", vote_count - base_votes, 1);
    checkOutput("t1_pattern", last_vote, 4'b0001);
    checkOutput("t1_latency", vote_cyc - press_cyc, 11);
    checkOutput("t1_total", total_votes, 1);
    checkOutput("t1_held_ready", voter_ready, 0);
    applyStimulus(4'b0000);
    wait_cycles(2);
    checkOutput("t1_idle_ready", voter_ready, 0);

    // No arm: presses ignored.
    snapshot();
    applyStimulus(4'b0010);
    wait_cycles(20);
    checkOutput("t2_votes", vote_count - base_votes, 0);
    checkOutput("t2_total", total_votes, 1);
    checkOutput("t2_ready", voter_ready, 0);
    applyStimulus(4'b0000);
    wait_cycles(2);

    // Multi-press reject, then retry without re-arm.
    arm_voter();
    snapshot();
    applyStimulus(4'b0110);
    wait_cycles(20);
    checkOutput("t3_rejects", reject_count - base_rejects, 1);
    checkOutput("t3_votes", vote_count - base_votes, 0);
    checkOutput("t3_held_ready", voter_ready, 0);
    applyStimulus(4'b0000);
    wait_cycles(2);
    checkOutput("t3_retry_ready", voter_ready, 1);
    snapshot();
    applyStimulus(4'b0100);
    wait_cycles(20);
    checkOutput("t3_votes2", vote_count - base_votes, 1);
    checkOutput("t3_pattern", last_vote, 4'b0100);
    checkOutput("t3_total", total_votes, 2);
    applyStimulus(4'b0000);
    wait_cycles(2);

    // Bouncing button1, then a clean settle.
    arm_voter();
    snapshot();
    for (int i = 0; i < 50; i++) begin
      applyStimulus(((i / 3) % 2 == 0) ? 4'b0001 : 4'b0000);
      @(negedge clock);
    end
    checkOutput("t4_bounce_votes", vote_count - base_votes, 0);
    applyStimulus(4'b0000);
    @(negedge clock);
    press_cyc = cyc;
    applyStimulus(4'b0001);
    wait_cycles(20);
    checkOutput("t4_votes", vote_count - base_votes, 1);
    checkOutput("t4_pattern", last_vote, 4'b0001);
    checkOutput("t4_latency", vote_cyc - press_cyc, 11);
    checkOutput("t4_total", total_votes, 3);
    applyStimulus(4'b0000);
    wait_cycles(2);

    // Mode switch mid-debounce, then result display selection.
    arm_voter();
    snapshot();
    applyStimulus(4'b1000);
    wait_cycles(5);
    mode = 1'b1;
    wait_cycles(20);
    checkOutput("t5_votes", vote_count - base_votes, 0);
    checkOutput("t5_disp_valid", disp_valid, 1);
    checkOutput("t5_ready", voter_ready, 0);
    checkOutput("t5_sel_held_press", disp_sel, 0);
    applyStimulus(4'b0000);
    wait_cycles(2);
    applyStimulus(4'b0100);
    wait_cycles(2);
    checkOutput("t5_sel_b3", disp_sel, 2);
    applyStimulus(4'b0000);
    wait_cycles(2);
    applyStimulus(4'b0011);
    wait_cycles(2);
    checkOutput("t5_sel_multi", disp_sel, 2);
    applyStimulus(4'b0000);
    wait_cycles(2);
    applyStimulus(4'b1000);
    wait_cycles(2);
    checkOutput("t5_sel_b4", disp_sel, 3);
    applyStimulus(4'b0000);
    mode = 1'b0;
    wait_cycles(2);
    checkOutput("t5_disp_off", disp_valid, 0);
    checkOutput("t5_sel_hold", disp_sel, 3);
    checkOutput("t5_total", total_votes, 3);

    // Asynchronous reset in the middle of debouncing.
    arm_voter();
    snapshot();
    applyStimulus(4'b0010);
    wait_cycles(4);
    checkOutput("t6_pre_ready", voter_ready, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_ready", voter_ready, 0);
    checkOutput("t6_rst_total", total_votes, 0);
    checkOutput("t6_rst_sel", disp_sel, 0);
    @(negedge clock);
    reset = 1'b1;
    wait_cycles(20);
    checkOutput("t6_votes", vote_count - base_votes, 0);
    checkOutput("t6_total", total_votes, 0);
    applyStimulus(4'b0000);
    wait_cycles(2);

    // Saturation of total_votes at 255.
    snapshot();
    for (int v = 0; v < 256; v++) begin
      arm_voter();
      applyStimulus(4'b0001);
      wait_cycles(12);
      applyStimulus(4'b0000);
      wait_cycles(2);
    end
    checkOutput("t7_votes", vote_count - base_votes, 256);
    checkOutput("t7_total_sat", total_votes, 255);

    checkOutput("exclusive_strobes", conflicts, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Session controller in front of the votingMachine tally datapath.
- Gates each voter's turn behind an officer arm pulse and debounces the four candidate buttons.
- Rejects multi-button presses and issues exactly one one-hot increment pulse per accepted vote.
- In result mode it sequences which candidate's tally is selected for display.

Parameters:
- DEBOUNCE_CYCLES, 10, consecutive cycles the button pattern must stay stable before a decision; legal range 2..255.
- CNT_W, 8, width of total_votes; saturates at all-ones.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = voting, 1 = result display.
- arm  input  1  officer enable; single-cycle pulse admits one voter.
- button1..button4  input  1 each  candidate buttons, already synchronised upstream.
- vote_inc  output  4  one-hot, one-cycle increment strobe to the tally; bit0 = button1.
- voter_ready  output  1  high while a voter may press.
- reject  output  1  one-cycle pulse on an invalid (multi-button) press.
- disp_sel  output  2  candidate index whose tally is shown.
- disp_valid  output  1  high in RESULT state.
- total_votes  output  CNT_W  accepted-vote count.

Behaviour:
- Reset (reset=0, async): state IDLE; vote_inc=0, voter_ready=0, reject=0, disp_sel=0, disp_valid=0, total_votes=0; debounce counter and captured pattern cleared. Any state, including mid-debounce, is abandoned immediately.
- Notation: p = {button4,button3,button2,button1}, sampled every rising edge. All outputs are registered or Moore from registered state.
- IDLE:
  - mode=1 -> RESULT.
  - else arm=1 -> READY.
  - Buttons are ignored.
- READY: voter_ready=1.
  - mode=1 -> RESULT.
  - p!=0 -> DEBOUNCE; capture p; cnt=0.
- DEBOUNCE: voter_ready=1.
  - mode=1 -> RESULT, no vote.
  - p==0 -> READY (bounce).
  - p!=captured -> recapture, cnt=0.
  - p==captured and cnt<DEBOUNCE_CYCLES-1 -> cnt++.
  - p==captured and cnt==DEBOUNCE_CYCLES-1 -> decide:
    - captured one-hot -> COMMIT.
    - otherwise -> reject=1 for one cycle, go to RELEASE with flag rej=1.
- COMMIT (one cycle):
  - vote_inc = captured, total_votes += 1 (saturating).
  - -> RELEASE with rej=0.
  - mode is not sampled here; a committed vote always completes.
- RELEASE: voter_ready=0.
  - Waits for p==0.
  - rej=1 -> READY: the voter retries without a re-arm.
  - rej=0 -> IDLE: the next voter needs arm.
  - mode=1 while waiting -> RESULT.
- Latency: a stable single press first seen at edge E0 produces vote_inc high for exactly the cycle following edge E_DEBOUNCE_CYCLES.
- arm outside IDLE is ignored; there is no queueing.
- RESULT: disp_valid=1, voter_ready=0.
  - A new one-hot p (rising from p==0 on the previous cycle) sets disp_sel to its index.
  - Multi-press is ignored.
  - mode=0 -> IDLE; disp_sel holds its value.
- vote_inc and reject are never high together. vote_inc is never high outside the cycle after entering COMMIT.

Decomposition:
- Shared package vote_pkg holds:
  - the state enum (IDLE, READY, DEBOUNCE, COMMIT, RELEASE, RESULT);
  - N_CAND=4;
  - a onehot-check function;
  - a onehot-to-index function.
- One natural sub-module: vote_debounce (capture register + stability counter, outputs stable/pattern). FSM and counter stay in the top.

Test Plan (DEBOUNCE_CYCLES=10, 10 ns clock):
- Reset low 100 ns, release; arm pulse; button1 held 200 ns -> exactly one vote_inc=4'b0001 pulse 10 cycles after the press; total_votes=1; after release voter_ready=0.
- With no arm, button2 held 200 ns -> no vote_inc, total_votes unchanged.
- Arm; button2+button3 held 200 ns -> reject pulse once, no vote_inc; release -> READY; button3 held -> vote_inc=4'b0100.
- Arm; button1 toggled every 3 cycles for 50 cycles, then held stable -> no vote during the toggling; single vote_inc=4'b0001 10 cycles after it settles.
- Arm; press button4; set mode=1 at debounce cycle 5 -> no vote, disp_valid=1; then press button3 -> disp_sel=2.
- Assert reset for 1 cycle mid-DEBOUNCE -> all outputs return to reset values immediately; no vote_inc afterwards without a new arm.
